mem_port_arbiter: RTL and testbench

- Round-robin scheduler that shares one memory/bus port among four requesters (e.g. fetch, load/store, debug, DMA).
- Owns the select of the port's 4-input datapath mux: drives `sel_o` directly into it and holds the grant until the downstream port completes the transaction.
- Sits between the requester blocks and the shared memory interface in `computer_system`.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter owning the select of a 4-requester shared memory port.
// Optional BUSY timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    output logic [3:0] grant_o,
    output logic [1:0] sel_o,
    output logic       bus_valid_o,
    input  logic       bus_ready_i,
    output logic [3:0] done_o,
    output logic [3:0] err_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;

    logic [3:0] arb_req;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_vld;
    logic       timeout_hit;
    logic       txn_end;
    logic       load_grant;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] cnt_q, cnt_d;

    assign timeout_hit = (state_q == BUSY) && (cnt_q == TO_LIM);
`else
    // Parameter is inert here; the reference only keeps it visibly consumed.
    assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    // The just-served requester is excluded from the back-to-back decision.
    always_comb begin
        arb_req = req_i & ~((state_q == BUSY) ? grant_q : 4'b0000);
        win_vld = 1'b0;
        win_idx = last_q;
        cand    = last_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_q + k[1:0];
            if (!win_vld && arb_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign txn_end    = (state_q == BUSY) && (bus_ready_i || timeout_hit);
    assign load_grant = win_vld && ((state_q == IDLE) || txn_end);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        if (load_grant) begin
            state_d = BUSY;
            grant_d = 4'b0001 << win_idx;
            sel_d   = win_idx;
            last_d  = win_idx;
        end else if (txn_end) begin
            state_d = IDLE;
            grant_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        if (load_grant) begin
            cnt_d = '0;
        end else if ((state_q == BUSY) && !txn_end) begin
            cnt_d = cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= '1;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant_o     = grant_q;
    assign sel_o       = sel_q;
    assign bus_valid_o = (state_q == BUSY);
    assign busy_o      = bus_valid_o;
    assign done_o      = grant_q & {4{bus_valid_o & bus_ready_i}};
    assign err_o       = grant_q & {4{timeout_hit & ~bus_ready_i}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; timeout scenarios run when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       bus_valid;
    logic [3:0] done;
    logic [3:0] err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int exp_idx;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .grant_o     (grant),
        .sel_o       (sel),
        .bus_valid_o (bus_valid),
        .bus_ready_i (ready),
        .done_o      (done),
        .err_o       (err),
        .busy_o      (busy)
    );

    // Every completion must match the oldest expected requester index.
    always @(negedge clk) begin
        if (rst_n && (done !== 4'b0000)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done got=%b expected=none", done);
            end else begin
                exp_idx = exp_q.pop_front();
                if ((done !== 4'(1 << exp_idx)) || (sel !== 2'(exp_idx))) begin
                    bad++;
                    $display("FAIL sb_done got done=%b sel=%0d expected done=%b sel=%0d",
                             done, sel, 4'(1 << exp_idx), exp_idx);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({grant, sel, bus_valid, busy, done, err} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs got grant=%b sel=%0d valid=%b busy=%b done=%b err=%b expected all zero",
                     grant, sel, bus_valid, busy, done, err);
        end
        next_cycle();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ((bus_valid !== 1'b0) || (grant !== 4'b0000) || (done !== 4'b0000)) begin
                bad++;
                $display("FAIL idle_ready_ignored got valid=%b grant=%b done=%b expected 0/0000/0000",
                         bus_valid, grant, done);
            end
            next_cycle();
        end
        ready = 1'b0;
    endtask

    task automatic test_single();
        req   = 4'b0001;
        ready = 1'b0;
        exp_q.push_back(0);
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            ready = (c == 3);
            @(negedge clk);
            total++;
            if ((grant !== 4'b0001) || (sel !== 2'd0) || (bus_valid !== 1'b1) || (busy !== 1'b1)) begin
                bad++;
                $display("FAIL single_grant cyc=%0d got grant=%b sel=%0d valid=%b busy=%b expected 0001/0/1/1",
                         c, grant, sel, bus_valid, busy);
            end
            total++;
            if (done !== ((c == 3) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL single_done cyc=%0d got=%b expected=%b", c, done,
                         (c == 3) ? 4'b0001 : 4'b0000);
            end
            next_cycle();
        end
        req   = 4'b0000;
        ready = 1'b0;
        @(negedge clk);
        total++;
        if ((bus_valid !== 1'b0) || (grant !== 4'b0000) || (sel !== 2'd0)) begin
            bad++;
            $display("FAIL single_idle got valid=%b grant=%b sel=%0d expected 0/0000/0", bus_valid, grant, sel);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req   = 4'b1111;
        ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if ((grant !== 4'(1 << (k % 4))) || (sel !== 2'(k % 4)) || (bus_valid !== 1'b1)) begin
                bad++;
                $display("FAIL rr_grant step=%0d got grant=%b sel=%0d valid=%b expected grant=%b sel=%0d",
                         k, grant, sel, bus_valid, 4'(1 << (k % 4)), k % 4);
            end
            if (k == 7) req = 4'b0000;
            next_cycle();
        end
        ready = 1'b0;
        @(negedge clk);
        total++;
        if ((bus_valid !== 1'b0) || (sel !== 2'd3)) begin
            bad++;
            $display("FAIL rr_idle_sel got valid=%b sel=%0d expected 0/3", bus_valid, sel);
        end
    endtask

    task automatic test_drop();
        req   = 4'b0100;
        ready = 1'b0;
        exp_q.push_back(2);
        next_cycle();
        req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            ready = (c == 4);
            @(negedge clk);
            total++;
            if ((grant !== 4'b0100) || (done !== ((c == 4) ? 4'b0100 : 4'b0000))) begin
                bad++;
                $display("FAIL drop_hold cyc=%0d got grant=%b done=%b expected 0100/%b",
                         c, grant, done, (c == 4) ? 4'b0100 : 4'b0000);
            end
            next_cycle();
        end
        ready = 1'b0;
        @(negedge clk);
        total++;
        if ((bus_valid !== 1'b0) || (sel !== 2'd2)) begin
            bad++;
            $display("FAIL drop_idle got valid=%b sel=%0d expected 0/2", bus_valid, sel);
        end
    endtask

    task automatic test_masked();
        logic [3:0] exp_g[3];
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b1000;
        exp_g[2] = 4'b0001;
        req   = 4'b0001;
        ready = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(3);
        exp_q.push_back(0);
        next_cycle();
        req   = 4'b1001;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) req = 4'b0000;
            @(negedge clk);
            total++;
            if ((grant !== exp_g[k]) || (bus_valid !== 1'b1)) begin
                bad++;
                $display("FAIL masked_grant step=%0d got grant=%b valid=%b expected %b/1",
                         k, grant, bus_valid, exp_g[k]);
            end
            next_cycle();
        end
        ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus_valid !== 1'b0) begin
            bad++;
            $display("FAIL masked_idle got valid=%b expected 0", bus_valid);
        end
    endtask

    task automatic test_async_reset();
        req   = 4'b0010;
        ready = 1'b0;
        next_cycle();
        @(negedge clk);
        total++;
        if ((grant !== 4'b0010) || (sel !== 2'd1)) begin
            bad++;
            $display("FAIL areset_pre got grant=%b sel=%0d expected 0010/1", grant, sel);
        end
        #2;
        ready = 1'b1;
        rst_n = 1'b0;
        #1;
        total++;
        if ((grant !== 4'b0000) || (bus_valid !== 1'b0) || (sel !== 2'd0) || (done !== 4'b0000)) begin
            bad++;
            $display("FAIL areset_now got grant=%b valid=%b sel=%0d done=%b expected 0000/0/0/0000",
                     grant, bus_valid, sel, done);
        end
        #1;
        ready = 1'b0;
        rst_n = 1'b1;
        exp_q.push_back(1);
        next_cycle();
        ready = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        total++;
        if ((grant !== 4'b0010) || (done !== 4'b0010)) begin
            bad++;
            $display("FAIL areset_regrant got grant=%b done=%b expected 0010/0010", grant, done);
        end
        next_cycle();
        ready = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            req   = 4'b0010;
            ready = 1'b0;
            if (r == 1) exp_q.push_back(1);
            next_cycle();
            req = 4'b0000;
            for (int c = 0; c < 5; c++) begin
                ready = (r == 1) && (c == 4);
                @(negedge clk);
                total++;
                if ((grant !== 4'b0010) ||
                    (err !== (((r == 0) && (c == 4)) ? 4'b0010 : 4'b0000)) ||
                    (done !== (((r == 1) && (c == 4)) ? 4'b0010 : 4'b0000))) begin
                    bad++;
                    $display("FAIL timeout run=%0d cyc=%0d got grant=%b err=%b done=%b expected 0010/%b/%b",
                             r, c, grant, err, done,
                             ((r == 0) && (c == 4)) ? 4'b0010 : 4'b0000,
                             ((r == 1) && (c == 4)) ? 4'b0010 : 4'b0000);
                end
                next_cycle();
            end
            ready = 1'b0;
            @(negedge clk);
            total++;
            if ((bus_valid !== 1'b0) || (err !== 4'b0000)) begin
                bad++;
                $display("FAIL timeout_idle run=%0d got valid=%b err=%b expected 0/0000", r, bus_valid, err);
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        req   = 4'b0001;
        ready = 1'b0;
        exp_q.push_back(0);
        next_cycle();
        req = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            ready = (c == 19);
            @(negedge clk);
            total++;
            if ((grant !== 4'b0001) || (err !== 4'b0000)) begin
                bad++;
                $display("FAIL no_timeout cyc=%0d got grant=%b err=%b expected 0001/0000", c, grant, err);
            end
            next_cycle();
        end
        ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_masked();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got pending=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
